// File: rtl/axiuart_frame_pkg.sv
// Shared definitions for the UART-AXI4 bridge framers (host-to-device parser
// and device-to-host builder).
//   - SOF markers for both directions
//   - response status codes and transfer-size encodings
//   - resp_hdr_t : latched response header (status, echoed cmd, address)
//   - crc8_next  : one-byte CRC8 step (poly 0x07, MSB-first, no reflection)
//   - cmd_data_bytes : payload byte count implied by a command byte
package axiuart_frame_pkg;

  localparam logic [7:0] SOF_HOST_TO_DEVICE = 8'hA5;
  localparam logic [7:0] SOF_DEVICE_TO_HOST = 8'h5A;

  localparam logic [7:0] STATUS_OK        = 8'h00;
  localparam logic [7:0] STATUS_CRC       = 8'h01;
  localparam logic [7:0] STATUS_CMD_INV   = 8'h02;
  localparam logic [7:0] STATUS_ALIGN     = 8'h03;
  localparam logic [7:0] STATUS_TIMEOUT   = 8'h04;
  localparam logic [7:0] STATUS_LEN_RANGE = 8'h07;

  localparam logic [1:0] SIZE_8    = 2'b00;
  localparam logic [1:0] SIZE_16   = 2'b01;
  localparam logic [1:0] SIZE_32   = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef struct packed {
    logic [7:0]  status;
    logic [7:0]  cmd;
    logic [31:0] addr;
  } resp_hdr_t;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction

  // (len+1) beats of 1/2/4 bytes; the reserved size carries no payload.
  function automatic logic [6:0] cmd_data_bytes(input logic [7:0] cmd);
    logic [6:0] beats;
    beats = {3'b000, cmd[3:0]} + 7'd1;
    case (cmd[5:4])
      SIZE_8:  return beats;
      SIZE_16: return {beats[5:0], 1'b0};
      SIZE_32: return {beats[4:0], 2'b00};
      default: return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/frame_builder.sv
// Device-to-host response framer. Latches one response request and streams
//   SOF, STATUS, CMD, [ADDR0..3, DATA x N], CRC
// into the UART TX FIFO, one byte per accepted write, honouring tx_fifo_full.
// Ports:
//   clk, rst            clock, async active-high reset
//   build_start         one-cycle request, sampled only in IDLE
//   status_code, cmd_echo, addr_echo, resp_data   response contents
//   tx_fifo_data/wr_en  byte and write strobe to the TX FIFO
//   tx_fifo_full        FIFO backpressure
//   builder_busy        high whenever not IDLE
//   response_done       one-cycle pulse after the CRC byte is accepted
module frame_builder
  import axiuart_frame_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           build_start,
  input  logic [7:0]                     status_code,
  input  logic [7:0]                     cmd_echo,
  input  logic [31:0]                    addr_echo,
  input  logic [MAX_DATA_BYTES-1:0][7:0] resp_data,
  output logic [7:0]                     tx_fifo_data,
  output logic                           tx_fifo_wr_en,
  input  logic                           tx_fifo_full,
  output logic                           builder_busy,
  output logic                           response_done
);

  localparam int IDX_W = (MAX_DATA_BYTES > 1) ? $clog2(MAX_DATA_BYTES) : 1;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_SOF    = 4'd1;
  localparam logic [3:0] ST_STATUS = 4'd2;
  localparam logic [3:0] ST_CMD    = 4'd3;
  localparam logic [3:0] ST_ADDR0  = 4'd4;
  localparam logic [3:0] ST_ADDR1  = 4'd5;
  localparam logic [3:0] ST_ADDR2  = 4'd6;
  localparam logic [3:0] ST_ADDR3  = 4'd7;
  localparam logic [3:0] ST_DATA   = 4'd8;
  localparam logic [3:0] ST_CRC    = 4'd9;
  localparam logic [3:0] ST_DONE   = 4'd10;

  logic [3:0]                     state;
  resp_hdr_t                      hdr_q;
  logic [MAX_DATA_BYTES-1:0][7:0] data_q;
  logic [7:0]                     crc_q;
  logic [6:0]                     idx_q;

  logic [7:0] byte_sel;
  logic       emit;
  logic       accept;
  logic       read_ok;
  logic [6:0] n_bytes;

  assign read_ok = (hdr_q.status == STATUS_OK) && hdr_q.cmd[7];
  assign n_bytes = cmd_data_bytes(hdr_q.cmd);

  always_comb begin
    byte_sel = 8'h00;
    emit     = 1'b1;
    case (state)
      ST_SOF:    byte_sel = SOF_DEVICE_TO_HOST;
      ST_STATUS: byte_sel = hdr_q.status;
      ST_CMD:    byte_sel = hdr_q.cmd;
      ST_ADDR0:  byte_sel = hdr_q.addr[7:0];
      ST_ADDR1:  byte_sel = hdr_q.addr[15:8];
      ST_ADDR2:  byte_sel = hdr_q.addr[23:16];
      ST_ADDR3:  byte_sel = hdr_q.addr[31:24];
      ST_DATA:   byte_sel = data_q[idx_q[IDX_W-1:0]];
      ST_CRC:    byte_sel = crc_q;
      default:   emit     = 1'b0;
    endcase
  end

  assign accept        = emit && !tx_fifo_full;
  assign tx_fifo_data  = byte_sel;
  assign tx_fifo_wr_en = accept;
  assign builder_busy  = (state != ST_IDLE);
  assign response_done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      hdr_q  <= '0;
      data_q <= '0;
      crc_q  <= 8'h00;
      idx_q  <= 7'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (build_start) begin
            hdr_q  <= '{status: status_code, cmd: cmd_echo, addr: addr_echo};
            data_q <= resp_data;
            crc_q  <= 8'h00;
            idx_q  <= 7'd0;
            state  <= ST_SOF;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          if (accept) begin
            // SOF is outside the CRC, and the CRC byte itself is not folded in.
            if (state != ST_SOF && state != ST_CRC)
              crc_q <= crc8_next(crc_q, byte_sel);
            case (state)
              ST_SOF:    state <= ST_STATUS;
              ST_STATUS: state <= ST_CMD;
              ST_CMD:    state <= read_ok ? ST_ADDR0 : ST_CRC;
              ST_ADDR0:  state <= ST_ADDR1;
              ST_ADDR1:  state <= ST_ADDR2;
              ST_ADDR2:  state <= ST_ADDR3;
              ST_ADDR3:  state <= (n_bytes == 7'd0) ? ST_CRC : ST_DATA;
              ST_DATA: begin
                idx_q <= idx_q + 7'd1;
                if (idx_q == n_bytes - 7'd1) state <= ST_CRC;
              end
              ST_CRC:    state <= ST_DONE;
              default:   state <= ST_IDLE;
            endcase
          end else if (!emit) begin
            // Unused encodings recover to IDLE.
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/frame_builder.md
Name: frame_builder

Overview:
- Device-to-host transmit-side framer for the UART-AXI4 bridge, the counterpart of the host-to-device frame parser.
- Takes one response request from the command executor (status, echoed command, address, read data) and serialises the response frame into the UART TX FIFO, one byte per accepted write.
- Computes CRC8 on the fly and honours FIFO backpressure.

Parameters:
- MAX_DATA_BYTES, 64, depth of the resp_data array (16 x 32-bit beats).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- build_start  in  1  one-cycle request; sampled only in IDLE
- status_code  in  8  response status (0x00 OK, 0x01 CRC, 0x02 CMD_INV, 0x03 ALIGN, 0x04 TIMEOUT, 0x07 LEN_RANGE)
- cmd_echo  in  8  original command byte: [7]=RW (1=read), [5:4]=size, [3:0]=len-1
- addr_echo  in  32  original address
- resp_data  in  8 x MAX_DATA_BYTES  read data, byte 0 first
- tx_fifo_data  out  8  byte to TX FIFO
- tx_fifo_wr_en  out  1  write strobe
- tx_fifo_full  in  1  backpressure
- builder_busy  out  1  high in every state except IDLE
- response_done  out  1  one-cycle pulse after the CRC byte is accepted

Behaviour:
- Reset (async): state IDLE, all latched registers 0, CRC 0, tx_fifo_wr_en 0, tx_fifo_data 0x00, builder_busy 0, response_done 0.
- IDLE with build_start=1: latch status/cmd/addr/resp_data and clear CRC to 0x00. The next cycle is SOF.
- Latched inputs are frozen until the frame completes. build_start is ignored while busy; there is no queueing.
- Frame format:
  - Every response: SOF 0x5A, STATUS, CMD.
  - When status==0x00 and cmd[7]==1 only: ADDR0..ADDR3 (little-endian, byte0=addr[7:0]), then N data bytes.
  - Every response ends with the CRC byte.
- N = (len+1) x {1,2,4} for size {00,01,10}. size 11 gives N=0 and skips the DATA state. N ranges 1..64 and is held in 7 bits.
- States: IDLE, SOF, STATUS, CMD, ADDR0, ADDR1, ADDR2, ADDR3, DATA, CRC, DONE.
- Byte-emitting states:
  - tx_fifo_data is the state's byte and tx_fifo_wr_en = !tx_fifo_full (combinational).
  - The state advances only on a cycle where wr_en=1. When full, hold state and byte; no write occurs.
- DATA: 7-bit index starts at 0 and increments on each accepted byte. Leave DATA when the accepted byte has index N-1.
- CRC8 definition:
  - Polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Covers STATUS through the last data byte (SOF excluded).
  - Updated on each accepted byte.
  - The CRC state emits the current register value.
- DONE: response_done=1 for exactly one cycle, then IDLE. build_start is not accepted during DONE.
- Latency with no backpressure: SOF write on cycle 1 after build_start. Write/error response is 4 bytes on cycles 1-4, with response_done on cycle 5. A read-OK response emits 8+N bytes.
- Reset mid-frame: immediate abort to IDLE; no further writes. A partial frame left in the FIFO is not the block's concern.

Decomposition:
- Shared package axiuart_frame_pkg holds:
  - SOF_HOST_TO_DEVICE=0xA5 and SOF_DEVICE_TO_HOST=0x5A.
  - The status code constants.
  - The size encodings.
  - A pure function crc8_next(crc, byte) and a function cmd_data_bytes(cmd) returning 7 bits.
- The parser adopts the same package.
- No sub-module; CRC is a register plus the package function.

Test Plan:
- Write ack: status 0x00, cmd 0x20, FIFO never full -> bytes 5A 00 20 E0 on 4 consecutive cycles; response_done on cycle 5; busy 0 on cycle 6.
- Error on read: status 0x01, cmd 0x80 -> bytes 5A 01 80 9C; no ADDR or data emitted.
- Read OK: status 0x00, cmd 0xA3 (32-bit, 4 beats), addr 0x12345678, resp_data[i]=i -> 5A 00 A3 78 56 34 12, then 00..0F (16 bytes), then CRC equal to the golden crc8_next model; 24 bytes total.
- Backpressure: same read with tx_fifo_full toggled pseudo-randomly (~50%) -> identical byte sequence; no write while full; no byte duplicated or skipped.
- build_start pulsed mid-frame with different inputs -> ignored; the current frame is unchanged and no second frame follows.
- rst asserted during DATA -> wr_en drops without waiting for a clock edge; IDLE, outputs at reset values; a new build_start afterwards produces a correct full frame.
